// File: rtl/alu_issue_ctrl.sv
// Issue stage in front of ALU32Bit: reads operands from a small register file, drives the ALU,
// waits out its latency, then writes the result back and reports it on the Wb* outputs.
module alu_issue_ctrl #(
   parameter int ALU_LATENCY = 1,
   parameter int NREGS       = 8
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        InValid,
   output logic        InReady,
   input  logic [3:0]  InOp,
   input  logic [2:0]  InRd,
   input  logic [2:0]  InRs,
   input  logic [2:0]  InRt,
   input  logic        InImmSel,
   input  logic [15:0] InImm,
   output logic [3:0]  ALUControl,
   output logic [31:0] A,
   output logic [31:0] B,
   input  logic [31:0] ALUResult,
   input  logic        Zero,
   output logic        WbValid,
   output logic [2:0]  WbRd,
   output logic [31:0] WbData,
   output logic        WbZero,
   input  logic [2:0]  DbgAddr,
   output logic [31:0] DbgData
);

   localparam int CW = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t         r_state, w_next;
   logic [CW-1:0]  r_cnt;
   logic [31:0]    r_rf [NREGS];
   logic [2:0]     r_rd;
   logic [3:0]     r_alu_ctl;
   logic [31:0]    r_a, r_b;
   logic [2:0]     r_wb_rd;
   logic [31:0]    r_wb_data;
   logic           r_wb_zero;

   logic           w_accept, w_capture;
   logic [31:0]    w_rs_val, w_rt_val, w_b_val;

   assign w_accept  = InValid && (r_state == S_IDLE);
   assign w_capture = (r_state == S_EXEC) && (r_cnt == '0);

   // Register 0 is hard-wired to zero on every read path
   assign w_rs_val = (InRs == 3'd0) ? 32'd0 : r_rf[InRs];
   assign w_rt_val = (InRt == 3'd0) ? 32'd0 : r_rf[InRt];
   assign w_b_val  = InImmSel ? {{16{InImm[15]}}, InImm} : w_rt_val;

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_EXEC;
         S_EXEC:  if (r_cnt == '0) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         r_cnt     <= '0;
         r_rd      <= '0;
         r_alu_ctl <= '0;
         r_a       <= '0;
         r_b       <= '0;
         r_wb_rd   <= '0;
         r_wb_data <= '0;
         r_wb_zero <= 1'b0;
         for (int i = 0; i < NREGS; i++) r_rf[i] <= '0;
      end else begin
         if (w_accept) begin
            r_alu_ctl <= InOp;
            r_a       <= w_rs_val;
            r_b       <= w_b_val;
            r_rd      <= InRd;
            r_cnt     <= CW'(ALU_LATENCY);
         end else if (r_state == S_EXEC && r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
         end
         // Writeback lands before the next accept can happen, so no forwarding path is needed
         if (w_capture) begin
            r_wb_data <= ALUResult;
            r_wb_zero <= Zero;
            r_wb_rd   <= r_rd;
            if (r_rd != 3'd0) r_rf[r_rd] <= ALUResult;
         end
      end
   end

   assign InReady    = (r_state == S_IDLE);
   assign WbValid    = (r_state == S_DONE);
   assign ALUControl = r_alu_ctl;
   assign A          = r_a;
   assign B          = r_b;
   assign WbRd       = r_wb_rd;
   assign WbData     = r_wb_data;
   assign WbZero     = r_wb_zero;
   assign DbgData    = (DbgAddr == 3'd0) ? 32'd0 : r_rf[DbgAddr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: ALU stub, transaction-level reference model with a per-cycle
// comparator, and directed scenarios with literal expectations.
module tb_alu_issue_ctrl;

   localparam int LAT = 1;

   logic        CLK = 1'b0;
   logic        Reset = 1'b1;
   logic        InValid = 1'b0;
   logic        InReady;
   logic [3:0]  InOp = '0;
   logic [2:0]  InRd = '0, InRs = '0, InRt = '0;
   logic        InImmSel = 1'b0;
   logic [15:0] InImm = '0;
   logic [3:0]  ALUControl;
   logic [31:0] A, B, ALUResult;
   logic        Zero;
   logic        WbValid;
   logic [2:0]  WbRd;
   logic [31:0] WbData;
   logic        WbZero;
   logic [2:0]  DbgAddr = '0;
   logic [31:0] DbgData;

   int checks = 0;
   int errors = 0;
   int wbcnt  = 0;

   always #5 CLK = ~CLK;

   alu_issue_ctrl #(.ALU_LATENCY(LAT), .NREGS(8)) dut (
      .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
      .InOp(InOp), .InRd(InRd), .InRs(InRs), .InRt(InRt),
      .InImmSel(InImmSel), .InImm(InImm),
      .ALUControl(ALUControl), .A(A), .B(B),
      .ALUResult(ALUResult), .Zero(Zero),
      .WbValid(WbValid), .WbRd(WbRd), .WbData(WbData), .WbZero(WbZero),
      .DbgAddr(DbgAddr), .DbgData(DbgData)
   );

   function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'd2:    return a + b;
         4'd6:    return a - b;
         default: return 32'd0;
      endcase
   endfunction

   // ALU stub: one register stage when LAT=1, pass-through when LAT=0
   logic [31:0] stub_comb, stub_q;
   assign stub_comb = alu_f(ALUControl, A, B);
   always @(posedge CLK) stub_q <= stub_comb;
   assign ALUResult = (LAT == 0) ? stub_comb : stub_q;
   assign Zero      = (ALUResult == 32'd0);

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
      end
   endtask

   // Reference model: m_t counts cycles since accept, -1 when ready for a new op
   int          m_t = -1;
   logic [31:0] m_rf [8];
   logic [3:0]  m_op = '0;
   logic [31:0] m_a = '0, m_b = '0, m_wbdata = '0;
   logic [2:0]  m_rd = '0, m_wbrd = '0;
   logic        m_wbzero = 1'b0;

   always @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         m_t <= -1; m_op <= '0; m_a <= '0; m_b <= '0; m_rd <= '0;
         m_wbdata <= '0; m_wbrd <= '0; m_wbzero <= 1'b0;
         for (int i = 0; i < 8; i++) m_rf[i] <= '0;
      end else if (m_t < 0) begin
         if (InValid) begin
            m_op <= InOp;
            m_rd <= InRd;
            m_a  <= (InRs == 0) ? 32'd0 : m_rf[InRs];
            m_b  <= InImmSel ? {{16{InImm[15]}}, InImm} : ((InRt == 0) ? 32'd0 : m_rf[InRt]);
            m_t  <= 0;
         end
      end else if (m_t == LAT) begin
         m_wbdata <= alu_f(m_op, m_a, m_b);
         m_wbzero <= (alu_f(m_op, m_a, m_b) == 32'd0);
         m_wbrd   <= m_rd;
         if (m_rd != 0) m_rf[m_rd] <= alu_f(m_op, m_a, m_b);
         m_t <= LAT + 1;
      end else if (m_t == LAT + 1) begin
         m_t <= -1;
      end else begin
         m_t <= m_t + 1;
      end
   end

   initial forever begin
      @(negedge CLK);
      chk("ready",   InReady,    (m_t < 0));
      chk("wbvalid", WbValid,    (m_t == LAT + 1));
      chk("wbrd",    WbRd,       m_wbrd);
      chk("wbdata",  WbData,     m_wbdata);
      chk("wbzero",  WbZero,     m_wbzero);
      chk("aluctl",  ALUControl, m_op);
      chk("a",       A,          m_a);
      chk("b",       B,          m_b);
      chk("dbg",     DbgData,    m_rf[DbgAddr]);
      if (WbValid) wbcnt++;
   end

   task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [2:0] rt, input logic sel, input logic [15:0] imm,
                        output logic [31:0] d, output logic z, output int lat);
      int n;
      @(negedge CLK);
      InOp = op; InRd = rd; InRs = rs; InRt = rt; InImmSel = sel; InImm = imm;
      InValid = 1'b1; DbgAddr = rd;
      n = 0;
      while (!InReady && n < 20) begin @(negedge CLK); n++; end
      chk("issue_ready", InReady, 1);
      @(posedge CLK);
      #1 InValid = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(negedge CLK);
         lat++;
         if (WbValid) break;
      end
      chk("wb_seen", WbValid, 1);
      d = WbData;
      z = WbZero;
      @(negedge CLK);
      chk("wb_pulse", WbValid, 0);
   endtask

   initial begin
      logic [31:0] d;
      logic        z;
      int          lat, wb0;

      // T1: reset state and mid-cycle reset
      repeat (2) @(negedge CLK);
      Reset = 1'b0;
      @(negedge CLK);
      chk("t1_ready", InReady, 1);
      for (int a = 0; a < 8; a++) begin
         DbgAddr = 3'(a);
         #1 chk("t1_dbg0", DbgData, 0);
      end
      issue(4'd2, 3'd5, 3'd0, 3'd0, 1'b1, 16'h1234, d, z, lat);
      chk("t1_pre_data", d, 32'h0000_1234);
      @(posedge CLK);
      #2 Reset = 1'b1;
      #1;
      chk("t1_rst_wbdata", WbData, 0);
      chk("t1_rst_wbrd", WbRd, 0);
      chk("t1_rst_b", B, 0);
      chk("t1_rst_ctl", ALUControl, 0);
      chk("t1_rst_dbg5", DbgData, 0);
      @(negedge CLK);
      Reset = 1'b0;

      // T2: immediate chain
      issue(4'd2, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5, d, z, lat);
      chk("t2_data1", d, 32'd5);
      chk("t2_lat1", lat, 3);
      issue(4'd2, 3'd2, 3'd1, 3'd0, 1'b1, 16'hFFFD, d, z, lat);
      chk("t2_data2", d, 32'd2);
      chk("t2_lat2", lat, 3);

      // T3: reg-reg subtract
      issue(4'd2, 3'd2, 3'd0, 3'd0, 1'b1, 16'd5, d, z, lat);
      issue(4'd6, 3'd3, 3'd1, 3'd2, 1'b0, 16'hAAAA, d, z, lat);
      chk("t3_sub_data", d, 32'd0);
      chk("t3_sub_zero", z, 1);
      DbgAddr = 3'd3;
      #1 chk("t3_dbg3", DbgData, 0);
      issue(4'd6, 3'd3, 3'd2, 3'd0, 1'b0, 16'h0, d, z, lat);
      chk("t3_sub2_data", d, 32'd5);
      chk("t3_sub2_zero", z, 0);

      // T4: sign extension, write to r0
      issue(4'd2, 3'd6, 3'd0, 3'd0, 1'b1, 16'h8000, d, z, lat);
      chk("t4_b", B, 32'hFFFF_8000);
      chk("t4_data", d, 32'hFFFF_8000);
      issue(4'd2, 3'd0, 3'd1, 3'd0, 1'b1, 16'd7, d, z, lat);
      chk("t4_r0_data", d, 32'd12);
      DbgAddr = 3'd0;
      #1 chk("t4_dbg0", DbgData, 0);

      // T5: continuous request with changing ops
      wb0 = wbcnt;
      @(negedge CLK);
      for (int c = 0; c < 16; c++) begin
         InValid  = 1'b1;
         InOp     = (c % 2 == 1) ? 4'd6 : 4'd2;
         InRd     = 3'(c % 7 + 1);
         InRs     = 3'(c % 4);
         InRt     = 3'((c + 1) % 8);
         InImmSel = (c % 3 == 0);
         InImm    = 16'(c * 3 + 1);
         DbgAddr  = 3'(c % 8);
         @(negedge CLK);
      end
      InValid = 1'b0;
      repeat (6) @(negedge CLK);
      chk("t5_accepts", wbcnt - wb0, 4);

      // T6: reset during EXEC drops the op
      @(negedge CLK);
      InOp = 4'd2; InRd = 3'd4; InRs = 3'd0; InImmSel = 1'b1; InImm = 16'd9; InValid = 1'b1;
      DbgAddr = 3'd4;
      @(posedge CLK);
      #1 InValid = 1'b0;
      @(negedge CLK);
      chk("t6_in_exec", InReady, 0);
      #2 Reset = 1'b1;
      @(negedge CLK);
      Reset = 1'b0;
      wb0 = wbcnt;
      repeat (5) @(negedge CLK);
      chk("t6_no_wb", wbcnt - wb0, 0);
      chk("t6_dbg4", DbgData, 0);
      issue(4'd2, 3'd4, 3'd0, 3'd0, 1'b1, 16'd7, d, z, lat);
      chk("t6_next_data", d, 32'd7);
      chk("t6_next_lat", lat, 3);
      #1 chk("t6_dbg4_after", DbgData, 32'd7);

      repeat (2) @(negedge CLK);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout got=running exp=finished");
      $fatal(1, "bench timeout");
   end

endmodule
